// File: rtl/line_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : line_buf_pkg
// Brief    : Shared constants and helpers for the line_buf_sched slice.
// Revision : 1.0 - initial release
// ============================================================================
package line_buf_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // Bit positions inside the 4-bit border vector {top, bottom, left, right}
    localparam int BRD_TOP   = 3;
    localparam int BRD_BOT   = 2;
    localparam int BRD_LEFT  = 1;
    localparam int BRD_RIGHT = 0;

endpackage
`default_nettype wire

// File: rtl/line_buf_sched_if.sv
`default_nettype none
// ============================================================================
// Interface: line_buf_sched_if
// Brief    : Video input, RAM control and post-RAM side-band bundle.
//            stat_lines exists only when LINE_BUF_STAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface line_buf_sched_if #(
    parameter int ADDR_W = 10
);
    logic              per_frame_vsync;
    logic              per_frame_href;
    logic              per_frame_clken;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_we;
    logic              bank_sel;
    logic              post_frame_vsync;
    logic              post_frame_href;
    logic              post_frame_clken;
    logic              win_valid;
    logic [3:0]        border;
    logic              err_flag;
`ifdef LINE_BUF_STAT_EN
    logic [ADDR_W+1:0] stat_lines;
`endif

    modport master (
`ifdef LINE_BUF_STAT_EN
        input  stat_lines,
`endif
        output per_frame_vsync, per_frame_href, per_frame_clken,
        input  ram_addr, ram_we, bank_sel,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  win_valid, border, err_flag
    );

    modport slave (
`ifdef LINE_BUF_STAT_EN
        output stat_lines,
`endif
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        output ram_addr, ram_we, bank_sel,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output win_valid, border, err_flag
    );

endinterface
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Brief    : Registers a level and flags its rising/falling edge in the
//            same cycle the new level is presented.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det (
    input  wire logic clock,
    input  wire logic rst_n,
    input  wire logic sig_i,
    output logic      rise_o,
    output logic      fall_o
);

    logic sig_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule
`default_nettype wire

// File: rtl/line_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : line_buf_sched
// Brief    : Column/row tracking, shared RAM addressing and bank rotation for
//            a two-bank 3-row line buffer; emits RAM-aligned side-band flags.
//            Define LINE_BUF_STAT_EN to add the stat_lines line counter.
// Revision : 1.0 - initial release
// ============================================================================
module line_buf_sched
    import line_buf_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int ADDR_W    = 10,
    parameter int RAM_LAT   = 1
) (
    input  wire logic       clock,
    input  wire logic       rst_n,
    line_buf_sched_if.slave bus
);

    localparam int COL_W  = ADDR_W + 1;
    localparam int ROW_W  = clog2(IMG_VDISP + 1);
    localparam int PIPE_W = 9;
    localparam int P_VS   = 8;
    localparam int P_HR   = 7;
    localparam int P_CK   = 6;
    localparam int P_BK   = 5;
    localparam int P_PR   = 4;

    logic             w_vs_rise;
    logic             w_unused_vs_fall;
    logic             w_hr_rise;
    logic             w_hr_fall;

    logic [COL_W-1:0]  col_q,      col_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic              wr_bank_q,  wr_bank_d;
    logic [1:0]        primed_q,   primed_d;
    logic              err_q,      err_d;
    logic              in_frame_q, in_frame_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;

    logic             w_line_ok;
    logic             w_acc;
    logic             w_drop;
    logic [1:0]       w_ram_we;
    logic [3:0]       w_border;
    logic [PIPE_W-1:0] w_pipe_in;
    logic [PIPE_W-1:0] w_pipe_out;
    logic [PIPE_W-1:0] pipe_q [RAM_LAT];

    sync_edge_det u_vs_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .sig_i  (bus.per_frame_vsync),
        .rise_o (w_vs_rise),
        .fall_o (w_unused_vs_fall)
    );

    sync_edge_det u_hr_edge (
        .clock  (clock),
        .rst_n  (rst_n),
        .sig_i  (bus.per_frame_href),
        .rise_o (w_hr_rise),
        .fall_o (w_hr_fall)
    );

    // Nothing is accepted after reset until a vsync rising edge opens a frame.
    assign w_line_ok = (row_q < ROW_W'(IMG_VDISP));
    assign w_acc     = in_frame_q & bus.per_frame_href & bus.per_frame_clken
                     & (col_q < COL_W'(IMG_HDISP)) & w_line_ok;
    assign w_drop    = in_frame_q & bus.per_frame_href & bus.per_frame_clken
                     & (col_q == COL_W'(IMG_HDISP));

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        wr_bank_d  = wr_bank_q;
        primed_d   = primed_q;
        err_d      = err_q;
        in_frame_d = in_frame_q;
        if (w_vs_rise) begin
            col_d      = '0;
            row_d      = '0;
            wr_bank_d  = BANK_A;
            primed_d   = 2'd0;
            err_d      = 1'b0;
            in_frame_d = 1'b1;
        end else if (in_frame_q) begin
            if (w_acc) begin
                col_d = col_q + COL_W'(1);
            end
            if (w_drop || (w_hr_rise && !w_line_ok)) begin
                err_d = 1'b1;
            end
            // Lines past the frame height are ignored entirely, bank included.
            if (w_hr_fall && w_line_ok) begin
                wr_bank_d = ~wr_bank_q;
                col_d     = '0;
                row_d     = row_q + ROW_W'(1);
                if (primed_q != 2'd2) begin
                    primed_d = primed_q + 2'd1;
                end
                if (col_q != COL_W'(IMG_HDISP)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ram_we = 2'b00;
        addr_d   = addr_q;
        w_border = 4'b0000;
        if (w_acc) begin
            w_ram_we[wr_bank_q] = 1'b1;
            addr_d              = col_q[ADDR_W-1:0];
            w_border[BRD_TOP]   = (row_q == ROW_W'(2));
            w_border[BRD_BOT]   = (row_q == ROW_W'(IMG_VDISP - 1));
            w_border[BRD_LEFT]  = (col_q == '0);
            w_border[BRD_RIGHT] = (col_q == COL_W'(IMG_HDISP - 1));
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            wr_bank_q  <= BANK_A;
            primed_q   <= 2'd0;
            err_q      <= 1'b0;
            in_frame_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            wr_bank_q  <= wr_bank_d;
            primed_q   <= primed_d;
            err_q      <= err_d;
            in_frame_q <= in_frame_d;
            addr_q     <= addr_d;
        end
    end

    // Side-band delay line matching the RAM read latency.
    assign w_pipe_in = {bus.per_frame_vsync, bus.per_frame_href, w_acc,
                        wr_bank_q, (primed_q == 2'd2), w_border};

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= w_pipe_in;
            for (int i = 1; i < RAM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign w_pipe_out = pipe_q[RAM_LAT-1];

    assign bus.ram_addr         = addr_d;
    assign bus.ram_we           = w_ram_we;
    assign bus.bank_sel         = w_pipe_out[P_BK];
    assign bus.post_frame_vsync = w_pipe_out[P_VS];
    assign bus.post_frame_href  = w_pipe_out[P_HR];
    assign bus.post_frame_clken = w_pipe_out[P_CK];
    assign bus.win_valid        = w_pipe_out[P_CK] & w_pipe_out[P_PR];
    assign bus.border           = w_pipe_out[3:0];
    assign bus.err_flag         = err_q;

`ifdef LINE_BUF_STAT_EN
    localparam int STAT_W = ADDR_W + 2;

    logic [STAT_W-1:0] lines_q, lines_d;
    logic [STAT_W-1:0] stat_q,  stat_d;

    // Counts every line end in the frame, including ignored extra lines.
    always_comb begin
        lines_d = lines_q;
        stat_d  = stat_q;
        if (w_vs_rise) begin
            stat_d  = lines_q;
            lines_d = '0;
        end else if (in_frame_q && w_hr_fall && (lines_q != '1)) begin
            lines_d = lines_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            lines_q <= '0;
            stat_q  <= '0;
        end else begin
            lines_q <= lines_d;
            stat_q  <= stat_d;
        end
    end

    assign bus.stat_lines = stat_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buf_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_buf_sched
// Brief    : Self-checking bench for line_buf_sched (8x4 image, RAM_LAT=3).
//            stat_lines checks are active when LINE_BUF_STAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_buf_sched;

    localparam int HD     = 8;
    localparam int VD     = 4;
    localparam int ADDR_W = 3;
    localparam int LAT    = 3;

    typedef struct packed {
        logic       win;
        logic [3:0] brd;
        logic       bank;
    } exp_t;

    typedef struct {
        int   nl;
        int   np;
        int   gap;
        int   exp_win;
        logic exp_err;
    } vec_t;

    logic clk;
    logic rst_n;

    int   n_chk;
    int   n_err;
    int   win_total;
    int   prev_lines;
    logic              exp_acc;
    logic [1:0]        exp_we;
    logic [ADDR_W-1:0] exp_addr;
    exp_t sb[$];

    line_buf_sched_if #(.ADDR_W(ADDR_W)) lb ();

    line_buf_sched #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .ADDR_W    (ADDR_W),
        .RAM_LAT   (LAT)
    ) dut (
        .clock (clk),
        .rst_n (rst_n),
        .bus   (lb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checks: exact post_* latency, write enables and scoreboard.
    task automatic monitor();
        logic [LAT-1:0] hv;
        logic [LAT-1:0] hh;
        logic [LAT-1:0] ha;
        exp_t           e;
        hv = '0;
        hh = '0;
        ha = '0;
        forever begin
            @(negedge clk);
            check("post_vsync", 32'(lb.post_frame_vsync), 32'(hv[LAT-1]));
            check("post_href",  32'(lb.post_frame_href),  32'(hh[LAT-1]));
            check("post_clken", 32'(lb.post_frame_clken), 32'(ha[LAT-1]));
            check("ram_we", 32'(lb.ram_we), 32'(exp_we));
            if (exp_we != 2'b00) begin
                check("ram_addr", 32'(lb.ram_addr), 32'(exp_addr));
            end
            if (lb.post_frame_clken) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("win_valid", 32'(lb.win_valid), 32'(e.win));
                    check("border",    32'(lb.border),    32'(e.brd));
                    check("bank_sel",  32'(lb.bank_sel),  32'(e.bank));
                end
                if (lb.win_valid) win_total++;
            end else begin
                check("win_idle", 32'(lb.win_valid), 32'd0);
            end
            hv = {hv[LAT-2:0], lb.per_frame_vsync};
            hh = {hh[LAT-2:0], lb.per_frame_href};
            ha = {ha[LAT-2:0], exp_acc};
            if (!rst_n) begin
                hv = '0;
                hh = '0;
                ha = '0;
            end
        end
    endtask

    task automatic pixel(input int r, input int c, input int gap);
        logic a;
        exp_t e;
        a = (c < HD) && (r < VD);
        lb.per_frame_clken = 1'b1;
        exp_acc  = a;
        exp_we   = a ? ((r % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_addr = ADDR_W'(c);
        if (a) begin
            e.win  = (r >= 2);
            e.brd  = {(r == 2), (r == VD - 1), (c == 0), (c == HD - 1)};
            e.bank = r[0];
            sb.push_back(e);
        end
        step();
        lb.per_frame_clken = 1'b0;
        exp_acc = 1'b0;
        exp_we  = 2'b00;
        repeat (gap) step();
    endtask

    task automatic frame_start();
        lb.per_frame_vsync = 1'b1;
        step();
        check("err_clear", 32'(lb.err_flag), 32'd0);
`ifdef LINE_BUF_STAT_EN
        check("stat_lines", 32'(lb.stat_lines), 32'(prev_lines));
`endif
        lb.per_frame_vsync = 1'b0;
        step();
        step();
    endtask

    task automatic run_frame(input vec_t v);
        int w0;
        frame_start();
        w0 = win_total;
        for (int r = 0; r < v.nl; r++) begin
            lb.per_frame_href = 1'b1;
            step();
            for (int c = 0; c < v.np; c++) begin
                pixel(r, c, v.gap);
            end
            lb.per_frame_href = 1'b0;
            repeat (3) step();
        end
        repeat (LAT + 2) step();
        check("win_count", 32'(win_total - w0), 32'(v.exp_win));
        check("err_flag",  32'(lb.err_flag),    32'(v.exp_err));
        check("sb_drain",  32'(sb.size()),      32'd0);
        prev_lines = v.nl;
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{nl: 4, np: 8,  gap: 0, exp_win: 16, exp_err: 1'b0};
        tbl[1] = '{nl: 4, np: 8,  gap: 2, exp_win: 16, exp_err: 1'b0};
        tbl[2] = '{nl: 4, np: 10, gap: 0, exp_win: 16, exp_err: 1'b1};
        tbl[3] = '{nl: 4, np: 6,  gap: 1, exp_win: 12, exp_err: 1'b1};
        tbl[4] = '{nl: 5, np: 8,  gap: 0, exp_win: 16, exp_err: 1'b1};
        tbl[5] = '{nl: 4, np: 8,  gap: 0, exp_win: 16, exp_err: 1'b0};

        n_chk      = 0;
        n_err      = 0;
        win_total  = 0;
        prev_lines = 0;
        exp_acc    = 1'b0;
        exp_we     = 2'b00;
        exp_addr   = '0;
        rst_n      = 1'b0;
        lb.per_frame_vsync = 1'b0;
        lb.per_frame_href  = 1'b0;
        lb.per_frame_clken = 1'b0;

        fork
            monitor();
        join_none

        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Reset in the middle of row 0, at column 3.
        frame_start();
        lb.per_frame_href = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            pixel(0, c, 0);
        end
        rst_n = 1'b0;
        lb.per_frame_href = 1'b0;
        step();
        sb.delete();
        check("rst_ram_we",     32'(lb.ram_we),           32'd0);
        check("rst_ram_addr",   32'(lb.ram_addr),         32'd0);
        check("rst_bank_sel",   32'(lb.bank_sel),         32'd0);
        check("rst_post_vsync", 32'(lb.post_frame_vsync), 32'd0);
        check("rst_post_href",  32'(lb.post_frame_href),  32'd0);
        check("rst_post_clken", 32'(lb.post_frame_clken), 32'd0);
        check("rst_win_valid",  32'(lb.win_valid),        32'd0);
        check("rst_border",     32'(lb.border),           32'd0);
        check("rst_err_flag",   32'(lb.err_flag),         32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i]);
        end

        // Closing vsync latches the last frame's line count.
        frame_start();
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
